ddr_responder: RTL and testbench

Behavioural DDR-side responder: the memory end of the simple request/valid protocol driven by the CPU memory controller. It accepts single-cycle write and read requests, stores words in an internal array, and returns read data after a fixed, parameterised latency with a one-cycle valid pulse. Used as the DDR stand-in in SoC simulation and FPGA bring-up. Reads are fully pipelined, so it also supports initiators that issue back-to-back reads.

---
 rtl/ddr_pkg.sv | 13 +
 rtl/ddr_rd_pipe.sv | 39 +++
 rtl/ddr_responder.sv | 85 ++++++++
 tb/tb_ddr_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - default geometry and read-return beat type shared by ddr_responder
package ddr_pkg;

    localparam int DDR_ADDR_WIDTH = 10;
    localparam int DDR_DATA_WIDTH = 32;
    localparam int DDR_RD_LATENCY = 4;

    typedef struct packed {
        logic                      valid;
        logic [DDR_DATA_WIDTH-1:0] data;
    } ddr_rd_beat_t;

endpackage

// File: rtl/ddr_rd_pipe.sv
// rtl/ddr_rd_pipe.sv - RD_LATENCY-stage read-return shift register with synchronous flush
// The last stage only reloads its data on a valid beat, so it doubles as the read-data hold register.
module ddr_rd_pipe
    import ddr_pkg::*;
#(
    parameter int RD_LATENCY = DDR_RD_LATENCY
) (
    input  logic         clk,
    input  logic         flush,
    input  ddr_rd_beat_t in_beat,
    output ddr_rd_beat_t out_beat
);

    ddr_rd_beat_t stage_q [RD_LATENCY];
    ddr_rd_beat_t stage_d [RD_LATENCY];

    always_comb begin
        stage_d[0] = in_beat;
        for (int i = 1; i < RD_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (!stage_d[RD_LATENCY-1].valid) begin
            stage_d[RD_LATENCY-1].data = stage_q[RD_LATENCY-1].data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RD_LATENCY; i++) begin
            if (flush) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_beat = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/ddr_responder.sv
// rtl/ddr_responder.sv - DDR-side request/valid responder: word array, pipelined reads, optional stats
// Optional feature: DDR_RESPONDER_STATS_EN enables the wr_count/rd_count registers.
module ddr_responder
    import ddr_pkg::*;
#(
    parameter int ADDR_WIDTH = DDR_ADDR_WIDTH,
    parameter int DATA_WIDTH = DDR_DATA_WIDTH,
    parameter int RD_LATENCY = DDR_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ddr_wr_req,
    input  logic                  ddr_rd_req,
    input  logic [ADDR_WIDTH-1:0] ddr_addr,
    input  logic [DATA_WIDTH-1:0] ddr_wr_data,
    output logic [DATA_WIDTH-1:0] ddr_rd_data,
    output logic                  ddr_rd_valid,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en;
    logic                  rd_en;
    ddr_rd_beat_t          rd_beat;
    ddr_rd_beat_t          ret_beat;

    // Read samples the array before this edge's write lands, giving read-first on collisions.
    always_comb begin
        wr_en         = ddr_wr_req && !reset;
        rd_en         = ddr_rd_req && !reset;
        rd_beat       = '0;
        rd_beat.valid = rd_en;
        rd_beat.data  = DDR_DATA_WIDTH'(mem_q[ddr_addr]);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ddr_addr] <= ddr_wr_data;
        end
    end

    ddr_rd_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .flush   (reset),
        .in_beat (rd_beat),
        .out_beat(ret_beat)
    );

    assign ddr_rd_valid = ret_beat.valid;
    assign ddr_rd_data  = DATA_WIDTH'(ret_beat.data);

`ifdef DDR_RESPONDER_STATS_EN
    logic [15:0] wr_count_q;
    logic [15:0] wr_count_d;
    logic [15:0] rd_count_q;
    logic [15:0] rd_count_d;

    always_comb begin
        wr_count_d = wr_count_q + 16'(wr_en);
        rd_count_d = rd_count_q + 16'(ret_beat.valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`else
    assign wr_count = 16'd0;
    assign rd_count = 16'd0;
`endif

endmodule

// File: tb/tb_ddr_responder.sv
// tb/tb_ddr_responder.sv - scoreboard bench for ddr_responder at latencies 4 and 1 sharing one stimulus stream
module tb_ddr_responder;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ddr_wr_req = 1'b0;
    logic        ddr_rd_req = 1'b0;
    logic [9:0]  ddr_addr = '0;
    logic [31:0] ddr_wr_data = '0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic [15:0] wr_count_a, rd_count_a, wr_count_b, rd_count_b;

    ddr_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset), .ddr_wr_req(ddr_wr_req), .ddr_rd_req(ddr_rd_req),
        .ddr_addr(ddr_addr), .ddr_wr_data(ddr_wr_data), .ddr_rd_data(rd_data_a),
        .ddr_rd_valid(rd_valid_a), .wr_count(wr_count_a), .rd_count(rd_count_a));

    ddr_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset), .ddr_wr_req(ddr_wr_req), .ddr_rd_req(ddr_rd_req),
        .ddr_addr(ddr_addr), .ddr_wr_data(ddr_wr_data), .ddr_rd_data(rd_data_b),
        .ddr_rd_valid(rd_valid_b), .wr_count(wr_count_b), .rd_count(rd_count_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq [2][$];
    int          lat [2] = '{LAT_A, LAT_B};
    logic [31:0] model [int];
    logic [31:0] last_data [2];
    int          cyc = 0;
    bit          rst_at_edge = 1'b1;
    int          total = 0;
    int          passed = 0;
    int          wcnt = 0;
    int          rcnt = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    always @(negedge clk) begin : monitor
        logic        v [2];
        logic [31:0] d [2];
        exp_t        e;
        v[0] = rd_valid_a; d[0] = rd_data_a;
        v[1] = rd_valid_b; d[1] = rd_data_b;
        for (int i = 0; i < 2; i++) begin
            if (rst_at_edge) begin
                chk($sformatf("reset_valid_%0d", i), 32'(v[i]), 32'd0);
                chk($sformatf("reset_data_%0d", i), d[i], 32'd0);
                last_data[i] = 32'd0;
            end else if (v[i]) begin
                if (sbq[i].size() == 0) begin
                    chk($sformatf("unexpected_valid_%0d", i), 32'(v[i]), 32'd0);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("rd_data_%0d", i), d[i], e.data);
                    chk($sformatf("latency_cycle_%0d", i), cyc, e.due);
                    last_data[i] = d[i];
                end
            end else begin
                chk($sformatf("hold_data_%0d", i), d[i], last_data[i]);
                if (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
                    chk($sformatf("missing_valid_%0d", i), 32'(v[i]), 32'd1);
                    void'(sbq[i].pop_front());
                end
            end
        end
    end

    task automatic step(input bit w, input bit r, input int a, input logic [31:0] d, input bit rst);
        ddr_wr_req  = w;
        ddr_rd_req  = r;
        ddr_addr    = a[9:0];
        ddr_wr_data = d;
        reset       = rst;
        if (rst) begin
            for (int i = 0; i < 2; i++)
                while (sbq[i].size() > 0 && sbq[i][$].due > cyc) void'(sbq[i].pop_back());
            wcnt = 0;
            rcnt = 0;
        end else begin
            if (r) begin
                for (int i = 0; i < 2; i++) sbq[i].push_back('{model[a], cyc + lat[i]});
                rcnt++;
            end
            if (w) begin
                model[a] = d;
                wcnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 32'd0, 1'b0);
    endtask

    task automatic check_counts(input string tag, input int ew, input int er);
        int xw;
        int xr;
`ifdef DDR_RESPONDER_STATS_EN
        xw = ew % 65536;
        xr = er % 65536;
`else
        xw = 0;
        xr = 0;
`endif
        chk({tag, "_wr_count_a"}, 32'(wr_count_a), 32'(xw));
        chk({tag, "_rd_count_a"}, 32'(rd_count_a), 32'(xr));
        chk({tag, "_wr_count_b"}, 32'(wr_count_b), 32'(xw));
        chk({tag, "_rd_count_b"}, 32'(rd_count_b), 32'(xr));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int  a;
        bit  w;
        bit  r;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset_wr_count_a", 32'(wr_count_a), 32'd0);
        chk("post_reset_rd_count_a", 32'(rd_count_a), 32'd0);

        step(1'b1, 1'b0, 'h005, 32'hDEADBEEF, 1'b0);
        step(1'b0, 1'b1, 'h005, 32'd0, 1'b0);
        idle(6);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i, 32'd0, 1'b0);
        idle(8);

        step(1'b1, 1'b0, 'h3FF, 32'h11111111, 1'b0);
        step(1'b1, 1'b1, 'h3FF, 32'h22222222, 1'b0);
        step(1'b0, 1'b1, 'h3FF, 32'd0, 1'b0);
        idle(6);

        step(1'b1, 1'b0, 'h000, 32'hA5A5A5A5, 1'b0);
        step(1'b0, 1'b1, 'h000, 32'd0, 1'b0);
        idle(6);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 4) == 0) ? 'h3FF : int'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 2) != 0) && model.exists(a);
            step(w, r, a, $urandom, 1'b0);
        end
        idle(8);
        check_counts("random", wcnt, rcnt);

        step(1'b1, 1'b0, 'h040, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 'h040, 32'd0, 1'b0);
        step(1'b1, 1'b0, 'h040, 32'hBAD0BAD0, 1'b1);
        chk("reset_clears_wr_count", 32'(wr_count_a), 32'd0);
        chk("reset_clears_rd_count", 32'(rd_count_a), 32'd0);
        idle(6);
        step(1'b0, 1'b1, 'h040, 32'd0, 1'b0);
        idle(6);

        step(1'b0, 1'b0, 0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 'h20 + i, 32'h5000 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 'h20 + i, 32'd0, 1'b0);
        idle(6);
        check_counts("stats", 5, 3);

        chk("drain_a", 32'(sbq[0].size()), 32'd0);
        chk("drain_b", 32'(sbq[1].size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
